me_candidate_scheduler: RTL

//  Sequences candidate motion vectors for one block of the 3D recursive-search motion estimator.
//  Per block it issues 6 candidates to the SAD datapath over a valid/ready handshake:

---
 rtl/me_candidate_scheduler.sv | 116 +++++++++++
 1 files changed

// File: rtl/me_candidate_scheduler.sv
// me_candidate_scheduler: issues 6 candidate MVs per block (S1,S2,T,S1+u,S2+u,zero) and tracks the min SAD.
// Optional macro UPD_PENALTY_EN adds PENALTY (saturating) to update-candidate SADs before comparing.
module me_candidate_scheduler #(
  parameter int VW      = 5,
  parameter int VMAX    = 7,
  parameter int SADW    = 16,
  parameter int PENALTY = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2*VW-1:0]   s1_vec,
  input  logic [2*VW-1:0]   s2_vec,
  input  logic [2*VW-1:0]   t_vec,
  output logic              upd_en,
  input  logic [5:0]        uvec,
  output logic              cand_valid,
  input  logic              cand_ready,
  output logic [2*VW-1:0]   cand_vec,
  output logic [2:0]        cand_idx,
  input  logic              sad_valid,
  input  logic [SADW-1:0]   sad,
  output logic              busy,
  output logic              done,
  output logic [2*VW-1:0]   best_vec,
  output logic [SADW-1:0]   best_sad
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
`ifdef UPD_PENALTY_EN
  localparam bit PEN_EN = 1'b1;
`else
  localparam bit PEN_EN = 1'b0;
`endif
  state_t state;
  logic [2*VW-1:0] s1_q, s2_q, t_q, run_vec, base, nxt_vec;
  logic [SADW-1:0] run_sad, cmp_sad;
  logic [SADW:0] pen_sum;
  logic signed [VW:0] ux, uy, sx, sy;
  logic is_upd, take;
  function automatic logic [VW-1:0] clamp(input logic signed [VW:0] v);
    return v > VMAX ? VW'(VMAX) : v < -VMAX ? VW'(-VMAX) : v[VW-1:0];
  endfunction
  assign is_upd = cand_idx == 3'd3 || cand_idx == 3'd4;
  assign base = (cand_idx == 3'd0 || cand_idx == 3'd3) ? s1_q :
                (cand_idx == 3'd1 || cand_idx == 3'd4) ? s2_q :
                (cand_idx == 3'd2) ? t_q : '0;
  // Update components are sign-extended into VW+1 bits so the sum cannot wrap before clamping
  assign ux = is_upd ? {{(VW-2){uvec[2]}}, uvec[2:0]} : '0;
  assign uy = is_upd ? {{(VW-2){uvec[5]}}, uvec[5:3]} : '0;
  assign sx = {base[VW-1], base[VW-1:0]} + ux;
  assign sy = {base[2*VW-1], base[2*VW-1:VW]} + uy;
  assign nxt_vec = {clamp(sy), clamp(sx)};
  assign pen_sum = {1'b0, sad} + (SADW+1)'(PENALTY);
  assign cmp_sad = (PEN_EN && is_upd) ? (pen_sum[SADW] ? '1 : pen_sum[SADW-1:0]) : sad;
  assign take = cand_idx == 3'd0 || cmp_sad < run_sad;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      upd_en     <= 1'b0;
      cand_valid <= 1'b0;
      cand_vec   <= '0;
      cand_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_vec   <= '0;
      best_sad   <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      t_q        <= '0;
      run_vec    <= '0;
      run_sad    <= '0;
    end else begin
      upd_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          s1_q     <= s1_vec;
          s2_q     <= s2_vec;
          t_q      <= t_vec;
          cand_idx <= '0;
          busy     <= 1'b1;
          state    <= ISSUE;
        end
        // First ISSUE cycle samples uvec (upd_en high), second onward presents the candidate
        ISSUE: if (!cand_valid) begin
          cand_vec   <= nxt_vec;
          cand_valid <= 1'b1;
        end else if (cand_ready) begin
          cand_valid <= 1'b0;
          state      <= WAIT;
        end
        WAIT: if (sad_valid) begin
          if (take) begin
            run_vec <= cand_vec;
            run_sad <= cmp_sad;
          end
          if (cand_idx == 3'd5) begin
            best_vec <= take ? cand_vec : run_vec;
            best_sad <= take ? cmp_sad : run_sad;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cand_idx <= cand_idx + 3'd1;
            upd_en   <= cand_idx == 3'd2 || cand_idx == 3'd3;
            state    <= ISSUE;
          end
        end
        default: begin
          cand_idx <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
